// File: rtl/apb_sample_mem.sv
// APB3 slave sample memory with configurable wait states.
// Word-addressed 32-bit storage that is preloaded by APB writes and read back by a
// sequential master. Out-of-range addresses and an access phase with no preceding
// setup phase complete with pslverr_o.
module apb_sample_mem #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        pclk_i,
    input  logic        presetn_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [7:0]  paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Configuration checks: the wait counter is 4 bits and paddr_i spans 256 words.
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("apb_sample_mem: WAIT_CYCLES must be 0..15");
    end
    if (DEPTH < 1 || DEPTH > 256) begin : g_bad_depth
        $error("apb_sample_mem: DEPTH must be 1..256");
    end

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_q;
    logic        write_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH];

    logic             in_range;
    logic [AddrW-1:0] rd_idx;
    logic [AddrW-1:0] wr_idx;
    logic [31:0]      rd_word;
    logic             in_access;
    logic             mem_we;

    assign in_range = 32'(paddr_i) < DEPTH;
    assign rd_idx   = paddr_i[AddrW-1:0];
    assign wr_idx   = addr_q[AddrW-1:0];
    assign rd_word  = in_range ? mem_q[rd_idx] : 32'h0;

    // StSetup covers the first access cycle, StAccess every later one. pready_o depends
    // only on psel/penable and registered state, never on the address path.
    assign in_access = psel_i & penable_i & ((state_q == StSetup) | (state_q == StAccess));
    assign pready_o  = in_access & (cnt_q == 4'd0);
    assign pslverr_o = pready_o & err_q;
    assign prdata_o  = (pready_o & ~write_q & ~err_q) ? rd_q : 32'h0;
    assign mem_we    = pready_o & write_q & ~err_q;

    // Phase tracking FSM: capture the transfer in the setup phase, count wait states.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 8'h0;
            wdata_q <= 32'h0;
            rd_q    <= 32'h0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (psel_i && !penable_i) begin
            // Setup phase: any state restarts here, including an abandoned access.
            state_q <= StSetup;
            cnt_q   <= 4'(WAIT_CYCLES);
            addr_q  <= paddr_i;
            wdata_q <= pwdata_i;
            rd_q    <= rd_word;
            write_q <= pwrite_i;
            err_q   <= ~in_range;
        end else if (!psel_i) begin
            // Deselect aborts any transfer in flight; no write is committed.
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Access phase without setup: error reply on the next cycle.
                    state_q <= StAccess;
                    cnt_q   <= 4'd0;
                    rd_q    <= 32'h0;
                    write_q <= 1'b0;
                    err_q   <= 1'b1;
                end
                StSetup, StAccess: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= StAccess;
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Sample storage: not reset, written on the completing edge of a legal write.
    always_ff @(posedge pclk_i) begin
        if (mem_we) begin
            mem_q[wr_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_sample_mem.sv
// Bench for apb_sample_mem: three instances cover WAIT_CYCLES=2, WAIT_CYCLES=0 and
// DEPTH=16. Expected responses are queued when a transfer is driven and popped when
// the selected instance raises pready_o.
module tb_apb_sample_mem;

    logic        clk;
    logic        presetn;
    logic        psel [3];
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata [3];
    logic        pready [3];
    logic        pslverr [3];

    int total;
    int bad;

    logic [31:0] exp_rd_q [$];
    logic        exp_err_q [$];
    int          exp_wait_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    apb_sample_mem #(.DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
        .pclk_i(clk), .presetn_i(presetn), .psel_i(psel[0]), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
        .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0])
    );

    apb_sample_mem #(.DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
        .pclk_i(clk), .presetn_i(presetn), .psel_i(psel[1]), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
        .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1])
    );

    apb_sample_mem #(.DEPTH(16), .WAIT_CYCLES(2)) u_d16 (
        .pclk_i(clk), .presetn_i(presetn), .psel_i(psel[2]), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
        .prdata_o(prdata[2]), .pready_o(pready[2]), .pslverr_o(pslverr[2])
    );

    // One full APB transfer on instance s; called and returns just after a rising edge.
    task automatic xfer(input int s, input logic wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] erd, input logic eerr,
                        input int ew, input string tag);
        int          waits;
        logic        done;
        logic [31:0] p_rd;
        logic        p_err;
        int          p_wait;
        exp_rd_q.push_back(erd);
        exp_err_q.push_back(eerr);
        exp_wait_q.push_back(ew);
        psel[s] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        @(posedge clk);
        #1 penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        while (!done && waits <= 32) begin
            @(negedge clk);
            if (pready[s] === 1'b1) done = 1'b1;
            else waits++;
        end
        p_rd   = exp_rd_q.pop_front();
        p_err  = exp_err_q.pop_front();
        p_wait = exp_wait_q.pop_front();
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no pready after %0d cycles", tag, waits);
        end else begin
            total++;
            if (prdata[s] !== p_rd) begin
                bad++;
                $display("FAIL %s prdata: got %h want %h", tag, prdata[s], p_rd);
            end
            total++;
            if (pslverr[s] !== p_err) begin
                bad++;
                $display("FAIL %s pslverr: got %b want %b", tag, pslverr[s], p_err);
            end
            total++;
            if (waits != p_wait) begin
                bad++;
                $display("FAIL %s waits: got %0d want %0d", tag, waits, p_wait);
            end
        end
        @(posedge clk);
        #1;
        psel[s] = 1'b0;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        #3;
        for (int s = 0; s < 3; s++) begin
            total++;
            if (pready[s] !== 1'b0 || pslverr[s] !== 1'b0 || prdata[s] !== 32'h0) begin
                bad++;
                $display("FAIL reset[%0d]: got rdy=%b err=%b rd=%h want 0 0 0",
                         s, pready[s], pslverr[s], prdata[s]);
            end
        end
        @(posedge clk);
        #1 presetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_wait_states();
        xfer(0, 1'b1, 8'd0, 32'h11, 32'h0, 1'b0, 2, "w2_wr0");
        xfer(0, 1'b1, 8'd1, 32'h22, 32'h0, 1'b0, 2, "w2_wr1");
        xfer(0, 1'b0, 8'd0, 32'h0, 32'h11, 1'b0, 2, "w2_rd0");
        xfer(0, 1'b0, 8'd1, 32'h0, 32'h22, 1'b0, 2, "w2_rd1");
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        time         t0;
        vals[0] = 32'hCAFE_0000;
        vals[1] = 32'h0000_BEEF;
        vals[2] = 32'h1357_9BDF;
        vals[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++)
            xfer(1, 1'b1, 8'(i), vals[i], 32'h0, 1'b0, 0, "w0_wr");
        t0 = $time;
        for (int i = 0; i < 4; i++)
            xfer(1, 1'b0, 8'(i), 32'h0, vals[i], 1'b0, 0, "w0_rd");
        total++;
        if ($time - t0 != 80) begin
            bad++;
            $display("FAIL w0_rate: got %0t want 80 for four reads", $time - t0);
        end
    endtask

    task automatic test_out_of_range();
        xfer(2, 1'b1, 8'h00, 32'h0000_00C0, 32'h0, 1'b0, 2, "d16_wr0");
        xfer(2, 1'b1, 8'h0F, 32'h0000_00CF, 32'h0, 1'b0, 2, "d16_wr15");
        xfer(2, 1'b0, 8'h10, 32'h0, 32'h0, 1'b1, 2, "d16_rd16");
        xfer(2, 1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0, 1'b1, 2, "d16_wr16");
        xfer(2, 1'b0, 8'h00, 32'h0, 32'h0000_00C0, 1'b0, 2, "d16_rd0");
        xfer(2, 1'b0, 8'h0F, 32'h0, 32'h0000_00CF, 1'b0, 2, "d16_rd15");
        xfer(2, 1'b0, 8'hFF, 32'h0, 32'h0, 1'b1, 2, "d16_rdff");
    endtask

    task automatic test_illegal();
        xfer(0, 1'b1, 8'd3, 32'h33, 32'h0, 1'b0, 2, "ill_pre");
        exp_rd_q.push_back(32'h0);
        exp_err_q.push_back(1'b1);
        psel[0] = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 8'd3;
        pwdata  = 32'h0BAD;
        @(negedge clk);
        total++;
        if (pready[0] !== 1'b0) begin
            bad++;
            $display("FAIL ill_idle_rdy: got %b want 0", pready[0]);
        end
        @(negedge clk);
        total++;
        if (pready[0] !== 1'b1) begin
            bad++;
            $display("FAIL ill_rdy: got %b want 1", pready[0]);
        end
        total++;
        if (pslverr[0] !== exp_err_q.pop_front()) begin
            bad++;
            $display("FAIL ill_err: got %b want 1", pslverr[0]);
        end
        total++;
        if (prdata[0] !== exp_rd_q.pop_front()) begin
            bad++;
            $display("FAIL ill_rd: got %h want 0", prdata[0]);
        end
        @(posedge clk);
        #1;
        psel[0] = 1'b0;
        penable = 1'b0;
        xfer(0, 1'b0, 8'd3, 32'h0, 32'h33, 1'b0, 2, "ill_rd3");
    endtask

    task automatic test_reset_mid_access();
        xfer(0, 1'b1, 8'd5, 32'h55, 32'h0, 1'b0, 2, "rst_pre5");
        psel[0] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'd5;
        pwdata  = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        presetn = 1'b0;
        #1;
        total++;
        if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0 || prdata[0] !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid: got rdy=%b err=%b rd=%h want 0 0 0",
                     pready[0], pslverr[0], prdata[0]);
        end
        psel[0] = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1 presetn = 1'b1;
        @(posedge clk);
        #1;
        xfer(0, 1'b0, 8'd5, 32'h0, 32'h55, 1'b0, 2, "rst_rd5");

        // Reset landing in the ready cycle itself must also drop the write.
        xfer(1, 1'b1, 8'd9, 32'h99, 32'h0, 1'b0, 0, "rst_pre9");
        psel[1] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'd9;
        pwdata  = 32'h5A5A;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        total++;
        if (pready[1] !== 1'b1) begin
            bad++;
            $display("FAIL rst_rdy_before: got %b want 1", pready[1]);
        end
        presetn = 1'b0;
        #1;
        total++;
        if (pready[1] !== 1'b0) begin
            bad++;
            $display("FAIL rst_rdy_after: got %b want 0", pready[1]);
        end
        @(posedge clk);
        #1;
        psel[1] = 1'b0;
        penable = 1'b0;
        presetn = 1'b1;
        @(posedge clk);
        #1;
        xfer(1, 1'b0, 8'd9, 32'h0, 32'h99, 1'b0, 0, "rst_rd9");
    endtask

    task automatic test_abort();
        xfer(0, 1'b1, 8'd7, 32'h77, 32'h0, 1'b0, 2, "abt_pre7");
        psel[0] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'd7;
        pwdata  = 32'h1234;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        total++;
        if (pready[0] !== 1'b0) begin
            bad++;
            $display("FAIL abt_wait: got %b want 0", pready[0]);
        end
        @(posedge clk);
        #1;
        psel[0] = 1'b0;
        penable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        xfer(0, 1'b0, 8'd7, 32'h0, 32'h77, 1'b0, 2, "abt_rd7");
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        presetn = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h0;
        pwdata  = 32'h0;
        for (int s = 0; s < 3; s++) psel[s] = 1'b0;
        test_reset();
        test_wait_states();
        test_back_to_back();
        test_out_of_range();
        test_illegal();
        test_reset_mid_access();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
